// File: rtl/strm_pkg.sv
// Shared types, soft-register map and constants for the streaming credit responder.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package strm_pkg;
    localparam int AXI_ADDR_W    = 64;
    localparam int AXI_DATA_W    = 512;
    localparam int AXI_STRB_W    = AXI_DATA_W / 8;
    localparam int RD_WORDS      = AXI_DATA_W / 32;
    localparam int MAX_GRANT_DEF = 64;

    // Soft-register offsets: writes
    localparam logic [31:0] SR_R_CRED_ADDR = 32'h00;
    localparam logic [31:0] SR_W_CRED_ADDR = 32'h08;
    localparam logic [31:0] SR_PEND_R_ADD  = 32'h10;
    localparam logic [31:0] SR_PEND_W_ADD  = 32'h18;
    // Soft-register offsets: reads
    localparam logic [31:0] SR_PEND_R      = 32'h20;
    localparam logic [31:0] SR_PEND_W      = 32'h28;
    localparam logic [31:0] SR_R_BEATS     = 32'h30;
    localparam logic [31:0] SR_W_BEATS     = 32'h38;
    localparam logic [31:0] SR_B_COUNT     = 32'h40;
    localparam logic [31:0] SR_ERR         = 32'h48;
    localparam logic [31:0] SR_W_MISMATCH  = 32'h50;

    localparam int ERR_WLAST_MISSING = 0;
    localparam int ERR_WLAST_EARLY   = 1;

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    // Credit top-up: clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/axi_bus_t.sv
// AXI bus bundle; the master modport is the memory-side responder view.
// Latency: none, wires only.
// Backpressure: plain AXI valid/ready on every channel.
interface axi_bus_t #(
    parameter int ID_WIDTH = 16
);
    logic                              arvalid, arready;
    logic [ID_WIDTH-1:0]               arid;
    logic [strm_pkg::AXI_ADDR_W-1:0]   araddr;
    logic [7:0]                        arlen;
    logic                              rvalid, rready, rlast;
    logic [ID_WIDTH-1:0]               rid;
    logic [strm_pkg::AXI_DATA_W-1:0]   rdata;
    logic [1:0]                        rresp;
    logic                              awvalid, awready;
    logic [ID_WIDTH-1:0]               awid;
    logic [strm_pkg::AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]                        awlen;
    logic                              wvalid, wready, wlast;
    logic [strm_pkg::AXI_DATA_W-1:0]   wdata;
    logic [strm_pkg::AXI_STRB_W-1:0]   wstrb;
    logic                              bvalid, bready;
    logic [ID_WIDTH-1:0]               bid;
    logic [1:0]                        bresp;

    modport master (
        input  arvalid, arid, araddr, arlen, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready,
        input  awvalid, awid, awaddr, awlen, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready
    );

    modport slave (
        output arvalid, arid, araddr, arlen, input arready,
        input  rvalid, rid, rdata, rresp, rlast, output rready,
        output awvalid, awid, awaddr, awlen, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready
    );
endinterface

// File: rtl/hull_fifo.sv
// Generic synchronous FIFO with show-ahead output.
// Latency: pushed entry visible on dout the cycle after push.
// Backpressure: full drops pushes, empty ignores pops; TYPE!=0 reports full one entry early.
module HullFIFO #(
    parameter int TYPE      = 0,
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] SLACK_C = (LOG_DEPTH + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_push, do_pop;

    assign full    = (TYPE == 0) ? (count == DEPTH_C) : (count >= SLACK_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written on accepted push only.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (LOG_DEPTH + 1)'(1);
                2'b01:   count <= count - (LOG_DEPTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/strm_resp_rd_engine.sv
// Read engine: accepts one AR burst at a time and returns mailbox grants or beat-index data.
// Latency: first R beat valid the cycle after AR accept, one beat per cycle when rready.
// Backpressure: arready only while idle; R beats hold until rready.
module strm_resp_rd_engine
    import strm_pkg::*;
#(
    parameter int ID_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  arvalid,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [7:0]            arlen,
    output logic                  arready,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    input  logic [AXI_ADDR_W-1:0] r_cred_addr,
    input  logic [AXI_ADDR_W-1:0] w_cred_addr,
    input  logic [31:0]           grant_r,
    input  logic [31:0]           grant_w,
    output logic                  poll_r,
    output logic                  poll_w,
    output logic                  r_fire
);
    rd_state_t           state_q, state_d;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q, beat_q;
    logic                mbox_q;
    logic [31:0]         grant_q;
    logic                ar_fire;

    assign ar_fire = arvalid && arready;
    // The read mailbox wins when both credit addresses are programmed equal.
    assign poll_r  = ar_fire && (araddr == r_cred_addr);
    assign poll_w  = ar_fire && (araddr != r_cred_addr) && (araddr == w_cred_addr);
    assign r_fire  = rvalid && rready;
    assign rid     = id_q;
    assign rresp   = 2'b00;
    assign rlast   = (state_q == RD_BURST) && (beat_q == len_q);

    // State register plus burst context latched at AR accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            mbox_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            if (ar_fire) begin
                id_q    <= arid;
                len_q   <= arlen;
                beat_q  <= '0;
                mbox_q  <= poll_r || poll_w;
                grant_q <= poll_r ? grant_r : grant_w;
            end else if (r_fire) begin
                beat_q  <= beat_q + 8'd1;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            RD_IDLE: begin
                arready = en;
                if (arvalid && en) state_d = RD_BURST;
            end
            RD_BURST: begin
                rvalid = 1'b1;
                if (rready && rlast) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // R data: grant in word 0 of beat 0 for mailbox polls, else beat index in every word.
    always_comb begin
        rdata = '0;
        if (mbox_q) begin
            if (beat_q == 8'd0) rdata[31:0] = grant_q;
        end else begin
            rdata = {RD_WORDS{32'(beat_q)}};
        end
    end
endmodule

// File: rtl/strm_cred_responder.sv
// AXI memory-side responder for the credit protocol; STRM_RESP_WCHECK_EN adds W data pattern checking.
// Latency: R data 1 cycle after AR accept, B 1 cycle after closing W beat, soft-reg reads 1 cycle.
// Backpressure: one read burst in flight; AW queued up to 2^AW_LOG_DEPTH; W stalls while B is pending.
module strm_cred_responder
    import strm_pkg::*;
#(
    parameter int ID_WIDTH     = 16,
    parameter int MAX_GRANT    = MAX_GRANT_DEF,
    parameter int AW_LOG_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_bus_t.master   axi_s,
    input  SoftRegReq  softreg_req,
    output SoftRegResp softreg_resp
);
    localparam logic [31:0] MAX_GRANT_32 = 32'(MAX_GRANT);

    logic                  live;
    logic [AXI_ADDR_W-1:0] r_cred_addr, w_cred_addr;
    logic [31:0]           pend_r, pend_w, grant_r, grant_w, add_r, add_w;
    logic [31:0]           r_beats, w_beats, b_count, w_mismatch_rd;
    logic [1:0]            err;
    logic                  poll_r, poll_w, r_fire, sr_wr, sr_rd;
    logic [63:0]           rd_dat;

    // Write-side state
    logic [ID_WIDTH+7:0]   aw_head;
    logic [ID_WIDTH-1:0]   head_id;
    logic [7:0]            head_len;
    logic                  aw_full, aw_empty, aw_push;
    logic [15:0]           wbeat;
    logic                  w_fire, w_end, len_hit, b_fire, bvalid;
    logic [ID_WIDTH-1:0]   bid;

    assign sr_wr   = softreg_req.valid && softreg_req.isWrite;
    assign sr_rd   = softreg_req.valid && !softreg_req.isWrite;
    assign grant_r = (pend_r > MAX_GRANT_32) ? MAX_GRANT_32 : pend_r;
    assign grant_w = (pend_w > MAX_GRANT_32) ? MAX_GRANT_32 : pend_w;
    assign add_r   = (sr_wr && softreg_req.addr == SR_PEND_R_ADD) ? softreg_req.data[31:0] : 32'd0;
    assign add_w   = (sr_wr && softreg_req.addr == SR_PEND_W_ADD) ? softreg_req.data[31:0] : 32'd0;

    strm_resp_rd_engine #(.ID_WIDTH(ID_WIDTH)) u_rd (
        .clk(clk), .rst_n(rst_n), .en(live),
        .arvalid(axi_s.arvalid), .arid(axi_s.arid), .araddr(axi_s.araddr), .arlen(axi_s.arlen),
        .arready(axi_s.arready),
        .rvalid(axi_s.rvalid), .rready(axi_s.rready), .rid(axi_s.rid), .rdata(axi_s.rdata),
        .rresp(axi_s.rresp), .rlast(axi_s.rlast),
        .r_cred_addr(r_cred_addr), .w_cred_addr(w_cred_addr),
        .grant_r(grant_r), .grant_w(grant_w),
        .poll_r(poll_r), .poll_w(poll_w), .r_fire(r_fire)
    );

    HullFIFO #(.TYPE(0), .WIDTH(ID_WIDTH + 8), .LOG_DEPTH(AW_LOG_DEPTH)) u_aw_q (
        .clk(clk), .rst_n(rst_n),
        .push(aw_push), .din({axi_s.awid, axi_s.awlen}),
        .pop(w_end), .dout(aw_head), .full(aw_full), .empty(aw_empty)
    );

    // Readies stay low through reset and come up the cycle after release.
    assign axi_s.awready = live && !aw_full;
    assign aw_push       = axi_s.awvalid && axi_s.awready;
    assign head_id       = aw_head[ID_WIDTH+7:8];
    assign head_len      = aw_head[7:0];
    assign axi_s.wready  = live && !aw_empty && !bvalid;
    assign w_fire        = axi_s.wvalid && axi_s.wready;
    assign len_hit       = (wbeat == {8'd0, head_len});
    // A burst closes on wlast or on reaching awlen, whichever comes first.
    assign w_end         = w_fire && (axi_s.wlast || len_hit);
    assign b_fire        = bvalid && axi_s.bready;
    assign axi_s.bvalid  = bvalid;
    assign axi_s.bid     = bid;
    assign axi_s.bresp   = 2'b00;

    // Credit bookkeeping, soft-register config and read counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live        <= 1'b0;
            r_cred_addr <= '0;
            w_cred_addr <= '0;
            pend_r      <= '0;
            pend_w      <= '0;
            r_beats     <= '0;
        end else begin
            live <= 1'b1;
            if (sr_wr && softreg_req.addr == SR_R_CRED_ADDR) r_cred_addr <= softreg_req.data;
            if (sr_wr && softreg_req.addr == SR_W_CRED_ADDR) w_cred_addr <= softreg_req.data;
            // Grant never exceeds pend, so the subtraction cannot underflow.
            pend_r <= sat_add32(pend_r - (poll_r ? grant_r : 32'd0), add_r);
            pend_w <= sat_add32(pend_w - (poll_w ? grant_w : 32'd0), add_w);
            if (r_fire) r_beats <= r_beats + 32'd1;
        end
    end

    // W beat tracking, B response generation and sticky protocol error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbeat   <= '0;
            w_beats <= '0;
            b_count <= '0;
            bvalid  <= 1'b0;
            bid     <= '0;
            err     <= '0;
        end else begin
            if (w_fire) w_beats <= w_beats + 32'd1;
            if (w_end) begin
                wbeat  <= '0;
                bvalid <= 1'b1;
                bid    <= head_id;
            end else if (w_fire) begin
                wbeat  <= wbeat + 16'd1;
            end else if (b_fire) begin
                bvalid <= 1'b0;
            end
            if (b_fire) b_count <= b_count + 32'd1;
            if (w_fire && axi_s.wlast && !len_hit) err[ERR_WLAST_EARLY]   <= 1'b1;
            if (w_fire && !axi_s.wlast && len_hit) err[ERR_WLAST_MISSING] <= 1'b1;
        end
    end

`ifdef STRM_RESP_WCHECK_EN
    logic [AXI_DATA_W-1:0] w_expect;
    logic                  w_bad;
    logic [31:0]           w_mismatch;
    logic                  unused_ok;

    // Compare enabled bytes of each W beat against the beat-index pattern.
    always_comb begin
        w_expect = {RD_WORDS{32'(wbeat)}};
        w_bad    = 1'b0;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            if (axi_s.wstrb[i] && (axi_s.wdata[8*i +: 8] != w_expect[8*i +: 8])) w_bad = 1'b1;
        end
    end

    // Saturating count of beats carrying at least one wrong byte.
    always_ff @(posedge clk) begin
        if (!rst_n)                                        w_mismatch <= '0;
        else if (w_fire && w_bad && w_mismatch != '1)      w_mismatch <= w_mismatch + 32'd1;
    end

    assign w_mismatch_rd = w_mismatch;
    assign unused_ok     = ^axi_s.awaddr;
`else
    logic unused_ok;
    assign w_mismatch_rd = '0;
    assign unused_ok     = ^{axi_s.awaddr, axi_s.wdata, axi_s.wstrb};
`endif

    // Soft-register read mux; unmapped offsets read zero.
    always_comb begin
        rd_dat = '0;
        case (softreg_req.addr)
            SR_PEND_R:     rd_dat = {32'd0, pend_r};
            SR_PEND_W:     rd_dat = {32'd0, pend_w};
            SR_R_BEATS:    rd_dat = {32'd0, r_beats};
            SR_W_BEATS:    rd_dat = {32'd0, w_beats};
            SR_B_COUNT:    rd_dat = {32'd0, b_count};
            SR_ERR:        rd_dat = {62'd0, err};
            SR_W_MISMATCH: rd_dat = {32'd0, w_mismatch_rd};
            default:       rd_dat = '0;
        endcase
    end

    // Registered soft-register response, one cycle after a read request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            softreg_resp <= '0;
        end else begin
            softreg_resp.valid <= sr_rd;
            softreg_resp.data  <= rd_dat;
        end
    end
endmodule
